// File: rtl/stopwatch_lap_timer.sv
// BCD M:SS.T up/down stopwatch with a tenth-second prescaler, a preset load
// for countdown, a lap-hold display register and a one-cycle done pulse on
// reaching the terminal value for the current count direction.
module stopwatch_lap_timer #(
    parameter int CLK_PER_TENTH = 10000,
    parameter int MAX_MINUTES   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clr,
    input  logic        dir,
    input  logic        load,
    input  logic [15:0] preset_bcd,
    input  logic        lap,
    output logic [3:0]  minutes,
    output logic [3:0]  seconds_msd,
    output logic [3:0]  seconds_lsd,
    output logic [3:0]  ms_msd,
    output logic        running,
    output logic        done,
    output logic        lap_active
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int              PW         = (CLK_PER_TENTH > 1) ? $clog2(CLK_PER_TENTH) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_TENTH - 1);
    localparam logic [3:0]      MAX_MIN_D  = 4'(MAX_MINUTES);
    localparam logic [15:0]     TERM_UP    = {MAX_MIN_D, 4'd5, 4'd9, 4'd9};
    localparam logic [15:0]     TERM_DOWN  = 16'h0000;

    // BCD increment of {min, sec_msd, sec_lsd, tenth}; callers never step
    // past the up terminal, so the minutes digit never overflows.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] m, sm, sl, t;
        {m, sm, sl, t} = v;
        if (t != 4'd9) begin
            t = t + 4'd1;
        end else begin
            t = 4'd0;
            if (sl != 4'd9) begin
                sl = sl + 4'd1;
            end else begin
                sl = 4'd0;
                if (sm != 4'd5) begin
                    sm = sm + 4'd1;
                end else begin
                    sm = 4'd0;
                    m  = m + 4'd1;
                end
            end
        end
        return {m, sm, sl, t};
    endfunction

    // BCD decrement; callers never step below 0:00.0.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m, sm, sl, t;
        {m, sm, sl, t} = v;
        if (t != 4'd0) begin
            t = t - 4'd1;
        end else begin
            t = 4'd9;
            if (sl != 4'd0) begin
                sl = sl - 4'd1;
            end else begin
                sl = 4'd9;
                if (sm != 4'd0) begin
                    sm = sm - 4'd1;
                end else begin
                    sm = 4'd5;
                    m  = m - 4'd1;
                end
            end
        end
        return {m, sm, sl, t};
    endfunction

    // A preset is usable only if every digit is in range for its position.
    function automatic logic bcd_valid(input logic [15:0] p);
        return (p[3:0]   <= 4'd9) &&
               (p[7:4]   <= 4'd9) &&
               (p[11:8]  <= 4'd5) &&
               (p[15:12] <= MAX_MIN_D);
    endfunction

    state_t        state, state_nxt;
    logic [15:0]   cnt, cnt_nxt, cnt_step;
    logic [15:0]   lap_reg, lap_reg_nxt;
    logic [15:0]   term_val;
    logic [15:0]   disp;
    logic [PW-1:0] presc, presc_nxt;
    logic          lap_act_nxt;
    logic          done_nxt;
    logic          at_term;
    logic          tick;
    logic          load_ok;
    logic          stop_ok;
    logic          start_ok;

    // Command qualification: which requests are legal in the current state.
    always_comb begin
        term_val = dir ? TERM_UP : TERM_DOWN;
        at_term  = (cnt == term_val);
        tick     = (state == S_RUN) && (presc == PRESC_LAST);
        load_ok  = load && (state != S_RUN) && bcd_valid(preset_bcd);
        stop_ok  = stop && (state == S_RUN);
        // stop in the same cycle suppresses start even where stop itself is a no-op
        start_ok = start && !stop && (state != S_RUN) && !at_term;
    end

    // Next state, count, prescaler and lap-hold with clr > load > stop > start.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        presc_nxt   = presc;
        done_nxt    = 1'b0;
        lap_reg_nxt = lap_reg;
        lap_act_nxt = lap_active;
        cnt_step    = dir ? bcd_inc(cnt) : bcd_dec(cnt);

        if (lap) begin
            if (lap_active) begin
                lap_act_nxt = 1'b0;
            end else if (state == S_RUN) begin
                lap_reg_nxt = cnt;
                lap_act_nxt = 1'b1;
            end
        end

        if (clr) begin
            cnt_nxt     = 16'h0000;
            state_nxt   = S_IDLE;
            presc_nxt   = '0;
            lap_act_nxt = 1'b0;
        end else if (load_ok) begin
            cnt_nxt   = preset_bcd;
            state_nxt = S_IDLE;
        end else if (stop_ok) begin
            state_nxt = S_PAUSED;
        end else if (start_ok) begin
            state_nxt = S_RUN;
            presc_nxt = '0;
        end else if (state == S_RUN) begin
            if (tick) begin
                presc_nxt = '0;
                if (at_term) begin
                    // dir flipped onto a value that is already terminal
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_step;
                    if (cnt_step == term_val) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Count, prescaler, lap register and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 16'h0000;
            presc      <= '0;
            lap_reg    <= 16'h0000;
            lap_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            presc      <= presc_nxt;
            lap_reg    <= lap_reg_nxt;
            lap_active <= lap_act_nxt;
            done       <= done_nxt;
        end
    end

    // Display mux between two registers, so digits move on the count edge.
    always_comb begin
        disp = lap_active ? lap_reg : cnt;
    end

    assign minutes     = disp[15:12];
    assign seconds_msd = disp[11:8];
    assign seconds_lsd = disp[7:4];
    assign ms_msd      = disp[3:0];
    assign running     = (state == S_RUN);

endmodule

// File: doc/stopwatch_lap_timer.md
Name: stopwatch_lap_timer

Overview:
Parametrised successor to the 4-digit stopwatch. It is a BCD M:SS.T up/down timer with an internal tenth-second prescaler, preset load for countdown, lap-hold display and a terminal "done" pulse. It sits between the debounced button/switch layer and the 7-segment display driver, and drives the same four digit outputs.

Parameters:
CLK_PER_TENTH, 10000, clk cycles per 0.1 s tick (10 ns clk gives 100 us per tick; benches use 10)
MAX_MINUTES, 9, upper limit of the minutes digit (1..9); up-count saturates at MAX_MINUTES:59.9

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, run request
stop  in  1  one-cycle pulse, pause request
clr  in  1  one-cycle pulse, zero value and return to IDLE
dir  in  1  1 = count up, 0 = count down; sampled on every tick
load  in  1  one-cycle pulse, load preset_bcd
preset_bcd  in  16  {min, sec_msd, sec_lsd, tenth}, 4 bits each
lap  in  1  one-cycle pulse, toggles lap hold
minutes  out  4  displayed minutes digit
seconds_msd  out  4  displayed seconds tens digit (0..5)
seconds_lsd  out  4  displayed seconds units digit (0..9)
ms_msd  out  4  displayed tenths digit (0..9)
running  out  1  high while state is RUN
done  out  1  one-cycle pulse on reaching the terminal value
lap_active  out  1  high while the display shows the held lap value

Behaviour:
- Reset: count = 0:00.0, lap register = 0, prescaler = 0, state = IDLE, lap_active = 0, done = 0, all digit outputs 0.
- States: IDLE, RUN, PAUSED, DONE.
- Input priority in one cycle: rst > clr > load > stop > start. lap is evaluated independently.
- Terminal value: MAX_MINUTES:59.9 when dir = 1; 0:00.0 when dir = 0.
- start:
  - Accepted in IDLE or PAUSED only if the count is not at the terminal value for the current dir. Otherwise it is ignored, with no done pulse.
  - Accepted in DONE under the same condition, e.g. after dir is changed.
  - Ignored in RUN.
  - On acceptance: state = RUN and prescaler = 0.
- stop: RUN -> PAUSED. Ignored in all other states. start and stop in the same cycle: stop wins, so no transition occurs from IDLE.
- Prescaler:
  - Counts only in RUN.
  - Issues a tick when it reaches CLK_PER_TENTH-1, then wraps to 0.
  - The first tick occurs exactly CLK_PER_TENTH cycles after the accepted start edge.
  - Held in PAUSED, but cleared again on resume.
- Tick, counting up: BCD increment with carries tenth 9->0, sec_lsd 9->0, sec_msd 5->0, into minutes.
- Tick, counting down: BCD decrement with borrows tenth 0->9, sec_lsd 0->9, sec_msd 0->5, from minutes.
- Reaching terminal on a tick: the new value registers on that edge, state = DONE, and done = 1 for exactly that cycle. The count never wraps or passes the terminal value.
- clr (any state): count = 0:00.0, state = IDLE, prescaler = 0, lap_active = 0, no done pulse.
- load:
  - Accepted in IDLE, PAUSED or DONE. Ignored in RUN.
  - Requires every digit to be valid: tenth ≤ 9, sec_lsd ≤ 9, sec_msd ≤ 5, min ≤ MAX_MINUTES. An invalid preset is ignored entirely.
  - On acceptance: count = preset and state = IDLE (DONE and PAUSED both go to IDLE).
- lap:
  - In RUN with lap_active = 0: copy the current count into the lap register and set lap_active = 1. Counting continues.
  - With lap_active = 1, in any state: clear lap_active.
  - In non-RUN with lap_active = 0: ignored.
- Display outputs show the lap register when lap_active = 1, and the live count otherwise. Both are registers feeding a mux, so there is no added latency: outputs change on the same edge as the count register.
- running = (state == RUN). done is registered.
- dir changed mid-run takes effect on the next tick. If the current value equals the new terminal, the next tick enters DONE without changing the value and pulses done.

Test Plan:
1. CLK_PER_TENTH=10, rst, dir=1, start -> ms_msd=1 exactly 10 cycles after start; after 1000 cycles display 0:10.0, running=1.
2. stop at 0:02.5, wait 500 cycles -> display stays 0:02.5, running=0. start -> first increment to 0:02.6 exactly 10 cycles later.
3. load 16'h9597, dir=1, start -> 9:59.8 then 9:59.9, done high for 1 cycle, state DONE. 200 further cycles hold 9:59.9. start ignored.
4. load 16'h0003, dir=0, start -> 0:00.2, 0:00.1, 0:00.0 with done pulse. Then load 16'h0600 (sec_msd=6) -> ignored, value stays 0:00.0.
5. Running up at 0:01.2, lap -> outputs frozen at 0:01.2 with lap_active=1 for 50 ticks. Second lap -> outputs show 0:06.2.
6. start+stop in the same cycle in IDLE -> stays IDLE. clr during RUN at 0:03.4 -> 0:00.0, IDLE. rst mid-run -> all outputs 0 on the next edge.
